// File: rtl/bus_pkg.sv
// Shared definitions for the cache memory bus: qword geometry, arbiter state
// encoding and the round-robin pick helper.
package bus_pkg;

    localparam int BUS_DATA_WIDTH_SHIFT = 4;
    localparam int BUS_DATA_WIDTH       = 128;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Round-robin pick between two requesters. On a tie the port that did not
    // win last time takes the bus; otherwise the only requester wins.
    function automatic logic pick_winner(
        input logic req0,
        input logic req1,
        input logic last_grant
    );
        logic w_win;
        if (req0 && req1) begin
            w_win = ~last_grant;
        end else if (req0) begin
            w_win = 1'b0;
        end else begin
            w_win = 1'b1;
        end
        return w_win;
    endfunction

endpackage

// File: rtl/cache_bus_arbiter_increment.sv
// Plain incrementer: data_o = data_i + 1, carry_o flags that data_i was
// already all-ones (i.e. the counter is saturated).
module increment #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             carry_o
);

    assign {carry_o, data_o} = {1'b0, data_i} + {{WIDTH{1'b0}}, 1'b1};

endmodule

// File: rtl/cache_bus_arbiter.sv
// Two-port round-robin arbiter sharing one 128-bit qword memory bus between
// the data cache (port 0) and the instruction cache (port 1). The grant is
// held until memory responds; a sticky watchdog flags a stalled memory.
module cache_bus_arbiter
    import bus_pkg::*;
#(
    parameter int BUS_ADDRESS_WIDTH = 20,
    parameter int TIMEOUT_WIDTH     = 8
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    // data cache
    input  logic [BUS_ADDRESS_WIDTH-1:BUS_DATA_WIDTH_SHIFT] m0_addr_i,
    input  logic [BUS_DATA_WIDTH-1:0]                     m0_data_i,
    input  logic                                          m0_we_i,
    input  logic                                          m0_valid_i,
    output logic                                          m0_valid_o,
    output logic [BUS_DATA_WIDTH-1:0]                     m0_data_o,
    // instruction cache
    input  logic [BUS_ADDRESS_WIDTH-1:BUS_DATA_WIDTH_SHIFT] m1_addr_i,
    input  logic [BUS_DATA_WIDTH-1:0]                     m1_data_i,
    input  logic                                          m1_we_i,
    input  logic                                          m1_valid_i,
    output logic                                          m1_valid_o,
    output logic [BUS_DATA_WIDTH-1:0]                     m1_data_o,
    // memory controller
    output logic [BUS_ADDRESS_WIDTH-1:BUS_DATA_WIDTH_SHIFT] mem_addr_o,
    output logic [BUS_DATA_WIDTH-1:0]                     mem_data_o,
    output logic                                          mem_we_o,
    output logic                                          mem_valid_o,
    input  logic                                          mem_valid_i,
    input  logic [BUS_DATA_WIDTH-1:0]                     mem_data_i,
    // watchdog
    output logic                                          timeout_o
);

    state_t r_state;
    state_t w_state_next;

    logic   r_grant;
    logic   r_last_grant;
    logic   r_mem_valid;
    logic   r_mem_we;
    logic   r_timeout;
    logic [BUS_ADDRESS_WIDTH-1:BUS_DATA_WIDTH_SHIFT] r_mem_addr;
    logic [BUS_DATA_WIDTH-1:0]                     r_mem_data;

    logic   w_any_req;
    logic   w_winner;
    logic   w_grant_en;
    logic   w_complete;
    logic   w_count_en;
    logic   w_busy;
    logic [BUS_ADDRESS_WIDTH-1:BUS_DATA_WIDTH_SHIFT] w_sel_addr;
    logic [BUS_DATA_WIDTH-1:0]                     w_sel_data;
    logic   w_sel_we;

    logic [TIMEOUT_WIDTH-1:0] r_wd;
    logic [TIMEOUT_WIDTH-1:0] w_wd_inc;
    logic                     w_wd_sat;

    assign w_any_req  = m0_valid_i | m1_valid_i;
    assign w_winner   = pick_winner(m0_valid_i, m1_valid_i, r_last_grant);
    assign w_busy     = (r_state == ST_BUSY);

    assign w_sel_addr = w_winner ? m1_addr_i : m0_addr_i;
    assign w_sel_data = w_winner ? m1_data_i : m0_data_i;
    assign w_sel_we   = w_winner ? m1_we_i   : m0_we_i;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state plus the grant / complete / watchdog-count strobes.
    always_comb begin
        w_state_next = r_state;
        w_grant_en   = 1'b0;
        w_complete   = 1'b0;
        w_count_en   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A memory strobe seen here belongs to nobody and is dropped.
                if (w_any_req) begin
                    w_grant_en   = 1'b1;
                    w_state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_valid_i) begin
                    w_complete   = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_count_en   = 1'b1;
                end
            end
        endcase
    end

    // Grant bookkeeping and the memory request strobe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_mem_valid  <= 1'b0;
        end else if (w_grant_en) begin
            r_grant      <= w_winner;
            r_last_grant <= w_winner;
            r_mem_valid  <= 1'b1;
        end else if (w_complete) begin
            r_mem_valid  <= 1'b0;
        end
    end

    // Latch the winner's request once; it is not re-sampled while BUSY.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_mem_we   <= 1'b0;
        end else if (w_grant_en) begin
            r_mem_addr <= w_sel_addr;
            r_mem_data <= w_sel_data;
            r_mem_we   <= w_sel_we;
        end
    end

    increment #(
        .WIDTH   (TIMEOUT_WIDTH)
    ) u_wd_inc (
        .data_i  (r_wd),
        .data_o  (w_wd_inc),
        .carry_o (w_wd_sat)
    );

    // Watchdog: count stalled BUSY cycles, saturate, clear on completion.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wd <= '0;
        end else if (w_complete) begin
            r_wd <= '0;
        end else if (w_count_en && !w_wd_sat) begin
            r_wd <= w_wd_inc;
        end
    end

    // Sticky timeout: set on the cycle the counter reaches all-ones.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_timeout <= 1'b0;
        end else if (w_count_en && !w_wd_sat && (&w_wd_inc)) begin
            r_timeout <= 1'b1;
        end
    end

    // The response is forwarded combinationally so the cache sees it in the
    // same cycle as the memory strobe; write responses are forwarded too.
    assign m0_valid_o  = mem_valid_i & w_busy & (r_grant == 1'b0);
    assign m1_valid_o  = mem_valid_i & w_busy & (r_grant == 1'b1);
    assign m0_data_o   = mem_data_i;
    assign m1_data_o   = mem_data_i;

    assign mem_addr_o  = r_mem_addr;
    assign mem_data_o  = r_mem_data;
    assign mem_we_o    = r_mem_we;
    assign mem_valid_o = r_mem_valid;
    assign timeout_o   = r_timeout;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Self-checking bench for cache_bus_arbiter: directed table, hand-written
// corner sequences and a randomized run against a transaction-level model.
module tb_cache_bus_arbiter;

    logic          clk;
    logic          rst;
    logic [15:0]   req_addr [2];
    logic [127:0]  req_data [2];
    logic          req_we   [2];
    logic          req_v    [2];
    logic          rsp_v    [2];
    logic [127:0]  rsp_d    [2];
    logic [15:0]   mem_addr_o;
    logic [127:0]  mem_data_o;
    logic          mem_we_o;
    logic          mem_valid_o;
    logic          mem_valid_in;
    logic [127:0]  mem_data_in;
    logic          timeout_o;

    int checks = 0;
    int errors = 0;

    cache_bus_arbiter #(
        .BUS_ADDRESS_WIDTH (20),
        .TIMEOUT_WIDTH     (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .m0_addr_i   (req_addr[0]),
        .m0_data_i   (req_data[0]),
        .m0_we_i     (req_we[0]),
        .m0_valid_i  (req_v[0]),
        .m0_valid_o  (rsp_v[0]),
        .m0_data_o   (rsp_d[0]),
        .m1_addr_i   (req_addr[1]),
        .m1_data_i   (req_data[1]),
        .m1_we_i     (req_we[1]),
        .m1_valid_i  (req_v[1]),
        .m1_valid_o  (rsp_v[1]),
        .m1_data_o   (rsp_d[1]),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_we_o    (mem_we_o),
        .mem_valid_o (mem_valid_o),
        .mem_valid_i (mem_valid_in),
        .mem_data_i  (mem_data_in),
        .timeout_o   (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tally(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        tally(name, 128'(act), 128'(exp));
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        tally(name, 128'(act), 128'(exp));
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic clear_inputs();
        for (int p = 0; p < 2; p++) begin
            req_v[p] = 1'b0; req_we[p] = 1'b0; req_addr[p] = '0; req_data[p] = '0;
        end
        mem_valid_in = 1'b0;
        mem_data_in  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One transaction for `port`, whose request is already being driven and
    // the arbiter is IDLE. Called at posedge+1; returns at posedge+1 after the
    // response edge with the request dropped.
    task automatic serve(input string tag, input int port, input int lat,
                         input logic [127:0] rdata, input logic perturb);
        logic [15:0]  e_addr;
        logic [127:0] e_data;
        logic         e_we;
        e_addr = req_addr[port];
        e_data = req_data[port];
        e_we   = req_we[port];
        #4;
        chk1($sformatf("%s_req_cycle_idle", tag), mem_valid_o, 1'b0);
        @(posedge clk); #1;
        chk1($sformatf("%s_mem_valid", tag), mem_valid_o, 1'b1);
        chk16($sformatf("%s_mem_addr", tag), mem_addr_o, e_addr);
        chk1($sformatf("%s_mem_we", tag), mem_we_o, e_we);
        tally($sformatf("%s_mem_data", tag), mem_data_o, e_data);
        if (perturb) begin
            req_addr[port] = ~e_addr;
            req_data[port] = ~e_data;
            req_we[port]   = ~e_we;
        end
        repeat (lat) begin
            @(posedge clk); #1;
            chk1($sformatf("%s_hold_valid", tag), mem_valid_o, 1'b1);
            chk16($sformatf("%s_hold_addr", tag), mem_addr_o, e_addr);
            chk1($sformatf("%s_hold_we", tag), mem_we_o, e_we);
            chk1($sformatf("%s_no_early_rsp", tag), rsp_v[0] | rsp_v[1], 1'b0);
        end
        mem_valid_in = 1'b1;
        mem_data_in  = rdata;
        #4;
        chk1($sformatf("%s_rsp_valid", tag), rsp_v[port], 1'b1);
        chk1($sformatf("%s_other_quiet", tag), rsp_v[1-port], 1'b0);
        tally($sformatf("%s_rsp_data", tag), rsp_d[port], rdata);
        @(posedge clk); #1;
        mem_valid_in = 1'b0;
        req_v[port]  = 1'b0;
    endtask

    typedef struct {
        logic         v0;
        logic         v1;
        logic [15:0]  a0;
        logic [15:0]  a1;
        logic [127:0] d0;
        logic [127:0] d1;
        logic         we0;
        logic         we1;
        int           lat;
        logic [127:0] rdata;
        int           first;
        logic         perturb;
    } vec_t;

    vec_t tbl [7];

    // Transaction-level reference for the randomized run.
    logic [15:0]  pa   [2];
    logic [127:0] pd   [2];
    logic         pwe  [2];
    logic         pend [2];
    logic         mdl_busy;
    int           mdl_grant;
    int           mdl_last;
    int           mdl_lat;
    logic [15:0]  mdl_addr;
    logic [127:0] mdl_data;
    logic         mdl_we;

    initial begin
        // fields: v0 v1 a0 a1 d0 d1 we0 we1 lat rdata first perturb
        tbl[0] = '{1'b1, 1'b1, 16'h0100, 16'h0200, 128'h11, 128'h22, 1'b0, 1'b0, 1,
                   128'hDEADBEEF_00000000_CAFEF00D_00000001, 0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 16'h0012, 16'h0000, 128'h0, 128'h0, 1'b0, 1'b0, 3,
                   {16{8'hA5}}, 0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 16'h0000, 16'hFFFF, 128'h0, {8{16'h1234}}, 1'b0, 1'b1, 3,
                   128'h0BAD, 1, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 16'h0000, 16'h0ABC, 128'h0, 128'h0, 1'b0, 1'b0, 0,
                   128'h01234567_89ABCDEF_FEDCBA98_76543210, 1, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 16'h1111, 16'h2222, 128'h1, 128'h2, 1'b1, 1'b0, 2,
                   128'h5555, 0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 16'h3333, 16'h0000, 128'h3333_0000, 128'h0, 1'b1, 1'b0, 0,
                   128'h7777, 0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 16'h4444, 16'h5555, 128'h44, 128'h55, 1'b0, 1'b0, 1,
                   128'h9999_8888, 1, 1'b0};

        rst = 1'b1;
        clear_inputs();

        // Reset state.
        #12;
        chk1("rst_mem_valid", mem_valid_o, 1'b0);
        chk1("rst_mem_we", mem_we_o, 1'b0);
        chk1("rst_timeout", timeout_o, 1'b0);
        chk16("rst_mem_addr", mem_addr_o, 16'h0);
        tally("rst_mem_data", mem_data_o, 128'h0);
        chk1("rst_rsp0", rsp_v[0], 1'b0);
        chk1("rst_rsp1", rsp_v[1], 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table; winners follow the round-robin history by hand.
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            req_v[0] = tbl[i].v0;  req_v[1] = tbl[i].v1;
            req_addr[0] = tbl[i].a0; req_addr[1] = tbl[i].a1;
            req_data[0] = tbl[i].d0; req_data[1] = tbl[i].d1;
            req_we[0] = tbl[i].we0; req_we[1] = tbl[i].we1;
            serve($sformatf("row%0d_a", i), tbl[i].first, tbl[i].lat, tbl[i].rdata, tbl[i].perturb);
            if (tbl[i].v0 && tbl[i].v1) begin
                serve($sformatf("row%0d_b", i), 1 - tbl[i].first, tbl[i].lat, ~tbl[i].rdata, 1'b0);
            end
        end

        // Continuous contention straight after reset: 0,1,0,1.
        do_reset();
        @(posedge clk); #1;
        req_v[0] = 1'b1; req_addr[0] = 16'h0100;
        req_v[1] = 1'b1; req_addr[1] = 16'h0200;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk1($sformatf("cont%0d_grant", k), mem_valid_o, 1'b1);
            chk16($sformatf("cont%0d_addr", k), mem_addr_o, (k % 2 == 0) ? 16'h0100 : 16'h0200);
            mem_valid_in = 1'b1;
            mem_data_in  = 128'(k);
            #4;
            chk1($sformatf("cont%0d_rsp", k), rsp_v[k % 2], 1'b1);
            chk1($sformatf("cont%0d_rsp_other", k), rsp_v[1 - (k % 2)], 1'b0);
            @(posedge clk); #1;
            mem_valid_in = 1'b0;
            #4;
            chk1($sformatf("cont%0d_idle", k), mem_valid_o, 1'b0);
        end
        @(posedge clk); #1;
        req_v[0] = 1'b0; req_v[1] = 1'b0;

        // Memory strobe while IDLE is ignored.
        do_reset();
        @(posedge clk); #1;
        mem_valid_in = 1'b1;
        mem_data_in  = 128'hF00D;
        #4;
        chk1("idle_strobe_rsp0", rsp_v[0], 1'b0);
        chk1("idle_strobe_rsp1", rsp_v[1], 1'b0);
        @(posedge clk); #1;
        mem_valid_in = 1'b0;
        #4;
        chk1("idle_strobe_state", mem_valid_o, 1'b0);
        @(posedge clk); #1;
        req_v[0] = 1'b1; req_addr[0] = 16'h0042; req_data[0] = 128'h42; req_we[0] = 1'b0;
        serve("after_idle_strobe", 0, 1, 128'hABCD, 1'b0);

        // Randomized traffic against the transaction-level model.
        do_reset();
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; pa[p] = '0; pd[p] = '0; pwe[p] = 1'b0;
        end
        mdl_busy = 1'b0; mdl_grant = 0; mdl_last = 1; mdl_lat = 0;
        mdl_addr = '0; mdl_data = '0; mdl_we = 1'b0;
        for (int cyc = 0; cyc < 700; cyc++) begin
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && cyc < 640 && $urandom_range(0, 3) == 0) begin
                    pend[p] = 1'b1;
                    pa[p]   = 16'($urandom);
                    pd[p]   = rand128();
                    pwe[p]  = 1'($urandom_range(0, 1));
                end
                req_v[p] = pend[p]; req_addr[p] = pa[p]; req_data[p] = pd[p]; req_we[p] = pwe[p];
            end
            mem_data_in = rand128();
            if (mdl_busy) mem_valid_in = (mdl_lat == 0);
            else          mem_valid_in = ($urandom_range(0, 7) == 0);
            #4;
            for (int p = 0; p < 2; p++) begin
                chk1("rnd_rsp_valid", rsp_v[p], mem_valid_in && mdl_busy && (mdl_grant == p));
                tally("rnd_rsp_data", rsp_d[p], mem_data_in);
            end
            chk1("rnd_mem_valid", mem_valid_o, mdl_busy);
            chk1("rnd_timeout", timeout_o, 1'b0);
            if (mdl_busy) begin
                chk16("rnd_mem_addr", mem_addr_o, mdl_addr);
                chk1("rnd_mem_we", mem_we_o, mdl_we);
                tally("rnd_mem_data", mem_data_o, mdl_data);
            end
            if (mdl_busy) begin
                if (mem_valid_in) begin
                    mdl_busy = 1'b0;
                    pend[mdl_grant] = 1'b0;
                end else begin
                    mdl_lat--;
                end
            end else if (pend[0] || pend[1]) begin
                if (pend[0] && pend[1]) mdl_grant = 1 - mdl_last;
                else                    mdl_grant = pend[0] ? 0 : 1;
                mdl_last = mdl_grant;
                mdl_busy = 1'b1;
                mdl_addr = pa[mdl_grant];
                mdl_data = pd[mdl_grant];
                mdl_we   = pwe[mdl_grant];
                mdl_lat  = $urandom_range(0, 5);
            end
        end
        chk1("rnd_drained", mdl_busy | pend[0] | pend[1], 1'b0);
        @(posedge clk); #1;
        clear_inputs();

        // Stalled memory: timeout after 15 BUSY cycles, grant held, late
        // completion still delivered, flag sticky.
        @(posedge clk); #1;
        req_v[0] = 1'b1; req_addr[0] = 16'h0777; req_we[0] = 1'b0;
        @(posedge clk); #1;
        chk1("wd_grant", mem_valid_o, 1'b1);
        for (int k = 1; k <= 18; k++) begin
            @(posedge clk); #1;
            chk1($sformatf("wd_timeout_k%0d", k), timeout_o, (k >= 15));
            chk1($sformatf("wd_hold_k%0d", k), mem_valid_o, 1'b1);
        end
        mem_valid_in = 1'b1;
        mem_data_in  = 128'h1A7E;
        #4;
        chk1("wd_late_rsp", rsp_v[0], 1'b1);
        tally("wd_late_data", rsp_d[0], 128'h1A7E);
        @(posedge clk); #1;
        mem_valid_in = 1'b0;
        req_v[0] = 1'b0;
        #4;
        chk1("wd_late_done", mem_valid_o, 1'b0);
        chk1("wd_sticky", timeout_o, 1'b1);

        // Asynchronous reset in the middle of a BUSY transaction.
        @(posedge clk); #1;
        req_v[1] = 1'b1; req_addr[1] = 16'h0333; req_data[1] = 128'h33; req_we[1] = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        chk1("areset_pre_busy", mem_valid_o, 1'b1);
        rst = 1'b1;
        #1;
        chk1("areset_mem_valid", mem_valid_o, 1'b0);
        chk1("areset_timeout", timeout_o, 1'b0);
        chk1("areset_mem_we", mem_we_o, 1'b0);
        chk16("areset_mem_addr", mem_addr_o, 16'h0);
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        req_v[1] = 1'b1; req_addr[1] = 16'h0444; req_data[1] = 128'h44; req_we[1] = 1'b0;
        serve("after_areset", 1, 2, 128'hBEEF, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got timeout expected completion");
        $fatal(1, "time limit");
    end

endmodule
